// File: rtl/tart_ddr_defs_pkg.sv
// Shared definitions for the TART DDR transmit path: FSM encodings, default
// word width and the IDDR2 alignment (training) pattern.
package tart_ddr_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Training drives a 1/0 pair every cycle, which looks like a DDR clock to the receiver.
  localparam logic TRAIN_D0 = 1'b1;
  localparam logic TRAIN_D1 = 1'b0;

  function automatic int pairs_per_word(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/ddr_tx_holdreg.sv
// One-entry holding register between the upstream valid/ready handshake and the
// shifter; a word accepted on the same edge the shifter loads bypasses the entry.
module ddr_tx_holdreg
  import tart_ddr_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             take_i,
  input  logic             block_i,
  output logic             ready_o,
  output logic             accept_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic full_n;

  assign accept_o = valid_i & ready_o;

  always_comb begin
    full_n = full_o;
    if (full_o) begin
      full_n = ~take_i;
    end else begin
      full_n = accept_o & ~take_i;
    end
  end

  // ready_o is registered from the next occupancy so valid_i never reaches it combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_o  <= 1'b0;
      data_o  <= '0;
      ready_o <= 1'b0;
    end else begin
      full_o  <= full_n;
      ready_o <= ~full_n & ~block_i;
      if (accept_o && !take_i) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/ddr_tx_serialiser.sv
// Word-to-DDR-pair serialiser feeding the D0/D1 inputs of a pad ODDR2, LSB first.
// Optional training pattern and train_i port are enabled by TART_DDR_TRAIN_EN.
module ddr_tx_serialiser
  import tart_ddr_defs::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   DELAY      = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             d0_o,
  output logic             d1_o,
  output logic             frame_o,
  output logic             busy_o
`ifdef TART_DDR_TRAIN_EN
  ,
  input  logic             train_i
`endif
);

  localparam int PAIRS = pairs_per_word(WIDTH);
  localparam int CNTW  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(PAIRS - 1);

  // DELAY only shapes the Icarus behavioural flow; this netlist has no delays.
  if (DELAY < 0) begin : g_negative_delay_ignored
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, src, hold_data;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic             d0_n, d1_n, frame_n, busy_n;
  logic             train, last, train_idle, take, block;
  logic             hold_full, accept, idle_d0, idle_d1;

`ifdef TART_DDR_TRAIN_EN
  assign train = train_i;
`else
  assign train = 1'b0;
`endif

  assign idle_d0 = train ? TRAIN_D0 : IDLE_LEVEL;
  assign idle_d1 = train ? TRAIN_D1 : IDLE_LEVEL;

  ddr_tx_holdreg #(.WIDTH(WIDTH)) u_hold (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .take_i   (take),
    .block_i  (block),
    .ready_o  (ready_o),
    .accept_o (accept),
    .full_o   (hold_full),
    .data_o   (hold_data)
  );

  assign last       = (state == ST_SHIFT) && (cnt == LAST_CNT);
  assign train_idle = (state == ST_IDLE) && train;
  assign take       = ce_i && !train_idle && (hold_full || accept) &&
                      ((state == ST_IDLE) || last);
  assign src        = hold_full ? hold_data : data_i;

  // A pending held word always has priority over a bypass, keeping word order intact.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    d0_n    = d0_o;
    d1_n    = d1_o;
    frame_n = frame_o;
    busy_n  = busy_o;
    if (take) begin
      state_n = ST_SHIFT;
      sr_n    = src >> 2;
      cnt_n   = '0;
      d0_n    = src[0];
      d1_n    = src[1];
      frame_n = 1'b1;
      busy_n  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          d0_n    = idle_d0;
          d1_n    = idle_d1;
          frame_n = 1'b0;
          busy_n  = 1'b0;
        end
        ST_SHIFT: begin
          if (ce_i) begin
            if (last) begin
              state_n = ST_IDLE;
              sr_n    = '0;
              cnt_n   = '0;
              d0_n    = idle_d0;
              d1_n    = idle_d1;
              frame_n = 1'b0;
              busy_n  = 1'b0;
            end else begin
              sr_n    = sr >> 2;
              cnt_n   = cnt + CNTW'(1);
              d0_n    = sr[0];
              d1_n    = sr[1];
              frame_n = 1'b0;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
    block = train && (state_n == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      sr      <= '0;
      cnt     <= '0;
      d0_o    <= IDLE_LEVEL;
      d1_o    <= IDLE_LEVEL;
      frame_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      d0_o    <= d0_n;
      d1_o    <= d1_n;
      frame_o <= frame_n;
      busy_o  <= busy_n;
    end
  end

endmodule

// File: tb/tb_ddr_tx_serialiser.sv
// Self-checking bench for ddr_tx_serialiser (WIDTH = 8, IDLE_LEVEL = 0); the
// training test is built only when TART_DDR_TRAIN_EN is defined.
`timescale 1ns/1ps
module tb_ddr_tx_serialiser;

  localparam int WIDTH = 8;
  localparam int PAIRS = WIDTH / 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             ce_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             d0_o, d1_o, frame_o, busy_o;
`ifdef TART_DDR_TRAIN_EN
  logic             train_i;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [2:0] obs_q[$];
  logic [2:0] exp_q[$];

  ddr_tx_serialiser #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0), .DELAY(0)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ce_i    (ce_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .d0_o    (d0_o),
    .d1_o    (d1_o),
    .frame_o (frame_o),
    .busy_o  (busy_o)
`ifdef TART_DDR_TRAIN_EN
    ,
    .train_i (train_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Pair k of a word is {bit 2k+1, bit 2k}, returned as {d1, d0}.
  function automatic logic [1:0] pair_of(input logic [WIDTH-1:0] w, input int k);
    return {w[2*k+1], w[2*k]};
  endfunction

  // Drives one cycle of inputs at the negedge and records what the next posedge transfers.
  task automatic cycle_drive(input logic v, input logic [WIDTH-1:0] d, input logic ce);
    @(negedge clk_i);
    valid_i = v;
    data_i  = d;
    ce_i    = ce;
    if (ce_i && busy_o) obs_q.push_back({frame_o, d1_o, d0_o});
    if (valid_i && ready_o) begin
      for (int k = 0; k < PAIRS; k++) exp_q.push_back({(k == 0), d[2*k+1], d[2*k]});
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_compared++;
    if ({d1_o, d0_o} !== 2'b00) begin
      n_mismatched++; $display("[TB] FAIL reset_data: got %b expected 00", {d1_o, d0_o});
    end
    n_compared++;
    if (frame_o !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_frame: got %b expected 0", frame_o);
    end
    n_compared++;
    if (busy_o !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
    end
    n_compared++;
    if (ready_o !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o);
    end
    rst_i = 1'b0;
    #1;
    n_compared++;
    if (ready_o !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL ready_before_edge: got %b expected 0", ready_o);
    end
    @(negedge clk_i);
    n_compared++;
    if (ready_o !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL ready_after_release: got %b expected 1", ready_o);
    end
  endtask

  task automatic test_single(input logic [WIDTH-1:0] w);
    @(negedge clk_i);
    ce_i = 1'b1; valid_i = 1'b1; data_i = w;
    @(negedge clk_i);
    valid_i = 1'b0;
    for (int k = 0; k < PAIRS; k++) begin
      n_compared++;
      if ({frame_o, busy_o, d1_o, d0_o} !== {(k == 0), 1'b1, pair_of(w, k)}) begin
        n_mismatched++;
        $display("[TB] FAIL single_pair%0d: got f/b/d1d0=%b expected %b", k,
                 {frame_o, busy_o, d1_o, d0_o}, {(k == 0), 1'b1, pair_of(w, k)});
      end
      @(negedge clk_i);
    end
    n_compared++;
    if ({frame_o, busy_o, d1_o, d0_o, ready_o} !== 5'b00001) begin
      n_mismatched++;
      $display("[TB] FAIL single_idle: got f/b/d1d0/rdy=%b expected 00001",
               {frame_o, busy_o, d1_o, d0_o, ready_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words[3];
    logic [2:0]       seen[$];
    logic [WIDTH-1:0] w;
    int idx = 0, pos = 0, prev_pos = 0, gaps = 0;
    bit prev_acc = 0, prev_busy = 0, started = 0, ended = 0;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hA5;
    ce_i = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk_i);
      if (busy_o) begin
        pos = frame_o ? 0 : pos + 1;
        if (ended) gaps++;
        started = 1;
        seen.push_back({frame_o, d1_o, d0_o});
      end else if (started) begin
        ended = 1;
      end
      if (prev_acc && prev_busy && prev_pos != PAIRS - 1) begin
        n_compared++;
        if (ready_o !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_ready_hold_full cyc%0d: got %b expected 0", cyc, ready_o);
        end
      end
      prev_busy = busy_o;
      prev_pos  = pos;
      valid_i   = (idx < 3);
      data_i    = (idx < 3) ? words[idx] : 8'h00;
      prev_acc  = valid_i && ready_o;
      if (prev_acc) idx++;
    end
    valid_i = 1'b0;
    n_compared++;
    if (idx !== 3) begin
      n_mismatched++; $display("[TB] FAIL b2b_accepted: got %0d expected 3", idx);
    end
    n_compared++;
    if (seen.size() !== 3 * PAIRS || gaps !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_contiguous: got %0d pairs %0d gap cycles expected %0d pairs 0 gaps",
               seen.size(), gaps, 3 * PAIRS);
    end
    for (int i = 0; i < seen.size() && i < 3 * PAIRS; i++) begin
      w = words[i / PAIRS];
      n_compared++;
      if (seen[i] !== {(i % PAIRS == 0), pair_of(w, i % PAIRS)}) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_pair%0d: got %b expected %b", i, seen[i],
                 {(i % PAIRS == 0), pair_of(w, i % PAIRS)});
      end
    end
  endtask

  task automatic test_ce_stall(input logic [WIDTH-1:0] w);
    int   seq[6]    = '{0, 1, 1, 1, 2, 3};
    logic cesch[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    @(negedge clk_i);
    ce_i = 1'b1; valid_i = 1'b1; data_i = w;
    @(negedge clk_i);
    valid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_compared++;
      if ({frame_o, busy_o, d1_o, d0_o} !== {(k == 0), 1'b1, pair_of(w, seq[k])}) begin
        n_mismatched++;
        $display("[TB] FAIL stall_cycle%0d: got f/b/d1d0=%b expected %b", k,
                 {frame_o, busy_o, d1_o, d0_o}, {(k == 0), 1'b1, pair_of(w, seq[k])});
      end
      ce_i = cesch[k];
      @(negedge clk_i);
    end
    n_compared++;
    if (busy_o !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL stall_end_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] a = 8'h3C, b = 8'h96, c = 8'h5A;
    @(negedge clk_i);
    ce_i = 1'b1; valid_i = 1'b1; data_i = a;
    @(negedge clk_i);
    data_i = b;
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    n_compared++;
    if ({busy_o, d1_o, d0_o} !== {1'b1, pair_of(a, 2)}) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_pre: got b/d1d0=%b expected %b", {busy_o, d1_o, d0_o},
               {1'b1, pair_of(a, 2)});
    end
    #1 rst_i = 1'b1;
    #1;
    n_compared++;
    if ({d1_o, d0_o, frame_o, busy_o, ready_o} !== 5'b00000) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_async: got d1d0/f/b/rdy=%b expected 00000",
               {d1_o, d0_o, frame_o, busy_o, ready_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      n_compared++;
      if ({busy_o, frame_o, d1_o, d0_o} !== 4'b0000) begin
        n_mismatched++;
        $display("[TB] FAIL midrst_no_resume%0d: got b/f/d1d0=%b expected 0000", k,
                 {busy_o, frame_o, d1_o, d0_o});
      end
    end
    n_compared++;
    if (ready_o !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL midrst_ready: got %b expected 1", ready_o);
    end
    valid_i = 1'b1; data_i = c;
    @(negedge clk_i);
    valid_i = 1'b0;
    n_compared++;
    if ({frame_o, busy_o, d1_o, d0_o} !== {2'b11, pair_of(c, 0)}) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_restart: got f/b/d1d0=%b expected %b",
               {frame_o, busy_o, d1_o, d0_o}, {2'b11, pair_of(c, 0)});
    end
    repeat (PAIRS + 1) @(negedge clk_i);
  endtask

  task automatic test_random();
    obs_q.delete();
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      cycle_drive($urandom_range(0, 99) < 60, WIDTH'($urandom), $urandom_range(0, 99) < 75);
      if (!busy_o) begin
        n_compared++;
        if ({frame_o, d1_o, d0_o} !== 3'b000) begin
          n_mismatched++;
          $display("[TB] FAIL rand_idle cyc%0d: got f/d1d0=%b expected 000", cyc,
                   {frame_o, d1_o, d0_o});
        end
      end
    end
    repeat (40) cycle_drive(1'b0, '0, 1'b1);
    n_compared++;
    if (obs_q.size() !== exp_q.size()) begin
      n_mismatched++;
      $display("[TB] FAIL rand_count: got %0d pairs expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_compared++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mismatched++;
        $display("[TB] FAIL rand_pair%0d: got f/d1d0=%b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef TART_DDR_TRAIN_EN
  task automatic test_train();
    @(negedge clk_i);
    ce_i = 1'b1; valid_i = 1'b0; train_i = 1'b1;
    repeat (2) @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if ({d0_o, d1_o, ready_o} !== 3'b100) begin
        n_mismatched++;
        $display("[TB] FAIL train_pattern%0d: got d0/d1/rdy=%b expected 100", k,
                 {d0_o, d1_o, ready_o});
      end
      @(negedge clk_i);
    end
    train_i = 1'b0;
    @(negedge clk_i);
    n_compared++;
    if ({d0_o, d1_o, ready_o} !== 3'b001) begin
      n_mismatched++;
      $display("[TB] FAIL train_release: got d0/d1/rdy=%b expected 001", {d0_o, d1_o, ready_o});
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    ce_i    = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
`ifdef TART_DDR_TRAIN_EN
    train_i = 1'b0;
`endif
    test_reset();
    test_single(8'hB4);
    test_back_to_back();
    repeat (2) @(negedge clk_i);
    test_ce_stall(8'hB4);
    test_reset_mid();
`ifdef TART_DDR_TRAIN_EN
    test_train();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
